// File: rtl/mem_pkg.sv
// Shared widths and grant encoding for the frame-buffer memory arbiter.
// Imported by the interface, FIFO and arbiter top.
package mem_pkg;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;
  localparam int LVL_W  = 3;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } gnt_e;
endpackage

// File: rtl/mem_arb_a_if.sv
// Pixel, read-port and BRAM bundle of the frame-buffer arbiter.
// The slave modport is the arbiter side.
interface mem_arb_a_if;
  import mem_pkg::*;

  logic [DATA_W-1:0] pixel_i;
  logic              pixel_en_i;
  logic              rd_req_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic              rd_gnt_o;
  logic              rd_valid_o;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_err_o;
  logic              ena_o;
  logic              wea_o;
  logic [ADDR_W-1:0] addra_o;
  logic [DATA_W-1:0] d2mema_o;
  logic [DATA_W-1:0] mem2da_i;
  logic              frame_done_o;
  logic              ovf_o;
  logic [LVL_W-1:0]  fifo_level_o;

  modport slave (
    input  pixel_i, pixel_en_i,
    input  rd_req_i, rd_addr_i,
    input  mem2da_i,
    output rd_gnt_o, rd_valid_o,
    output rd_data_o, rd_err_o,
    output ena_o, wea_o,
    output addra_o, d2mema_o,
    output frame_done_o, ovf_o,
    output fifo_level_o
  );

  modport master (
    output pixel_i, pixel_en_i,
    output rd_req_i, rd_addr_i,
    output mem2da_i,
    input  rd_gnt_o, rd_valid_o,
    input  rd_data_o, rd_err_o,
    input  ena_o, wea_o,
    input  addra_o, d2mema_o,
    input  frame_done_o, ovf_o,
    input  fifo_level_o
  );
endinterface

// File: rtl/px_fifo.sv
// Pixel write buffer: circular FIFO with first-word fall-through head.
// A push while full is accepted only when a pop frees the slot.
module px_fifo
  import mem_pkg::*;
#(
  parameter int DW    = DATA_W,
  parameter int DEPTH = 4,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [LW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == LW'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign dout    = mem[rp];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= nxt(wp);
      if (do_pop)  rp <= nxt(rp);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/mem_arb.sv
// Frame-buffer arbiter: pixel writes vs random reads on one BRAM port.
// Reads win unless the pixel FIFO reaches the starvation level.
module mem_arb_a
  import mem_pkg::*;
#(
  parameter int MAX_ROW    = 540,
  parameter int MAX_COL    = 540,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_TH  = 3
) (
  input logic        clk,
  input logic        rst,
  mem_arb_a_if.slave bus
);

  localparam int FRAME = MAX_ROW * MAX_COL;
  localparam int LW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W:0] FRAME_A =
    (ADDR_W + 1)'(FRAME);
  localparam logic [ADDR_W-1:0] LAST_A =
    ADDR_W'(FRAME - 1);

  gnt_e              gnt;
  gnt_e              last_gnt;
  logic [ADDR_W-1:0] wptr;
  logic              ovf;
  logic [DATA_W-1:0] head;
  logic              full;
  logic              empty;
  logic [LW-1:0]     lvl;
  logic              addr_ok;
  logic              starve;
  logic              pop;
  logic              rd_vld;

  assign addr_ok =
    ({1'b0, bus.rd_addr_i} < FRAME_A);
  assign starve  = (int'(lvl) >= STARVE_TH);
  assign pop     = (gnt == GNT_WR);

  px_fifo #(
    .DW    (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.pixel_en_i),
    .pop   (pop),
    .din   (bus.pixel_i),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (lvl)
  );

  always_comb begin
    gnt = GNT_NONE;
    if (rst)
      gnt = GNT_NONE;
    else if (starve)
      gnt = GNT_WR;
    else if (bus.rd_req_i && addr_ok)
      gnt = GNT_RD;
    else if (!empty)
      gnt = GNT_WR;
  end

  always_comb begin
    bus.ena_o    = 1'b0;
    bus.wea_o    = 1'b0;
    bus.addra_o  = '0;
    bus.d2mema_o = '0;
    unique case (gnt)
      GNT_WR: begin
        bus.ena_o    = 1'b1;
        bus.wea_o    = 1'b1;
        bus.addra_o  = wptr;
        bus.d2mema_o = head;
      end
      GNT_RD: begin
        bus.ena_o   = 1'b1;
        bus.addra_o = bus.rd_addr_i;
      end
      default: ;
    endcase
  end

  // Out-of-range reads never reach the BRAM; they only flag an error.
  assign bus.rd_gnt_o = (gnt == GNT_RD);
  assign bus.rd_err_o =
    !rst && bus.rd_req_i && !addr_ok;
  assign bus.frame_done_o =
    (gnt == GNT_WR) && (wptr == LAST_A);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      last_gnt <= GNT_NONE;
      ovf      <= 1'b0;
    end else begin
      last_gnt <= gnt;
      if (pop)
        wptr <= (wptr == LAST_A) ? '0
              : wptr + 1'b1;
      if (bus.pixel_en_i && full && !pop)
        ovf <= 1'b1;
    end
  end

  assign rd_vld           = (last_gnt == GNT_RD);
  assign bus.rd_valid_o   = rd_vld;
  assign bus.rd_data_o    =
    rd_vld ? bus.mem2da_i : '0;
  assign bus.ovf_o        = ovf;
  assign bus.fifo_level_o = LVL_W'(lvl);

endmodule

// File: tb/tb_mem_arb_a.sv
// Directed bench for mem_arb_a: default, 4x4-frame and
// starvation-override instances checked against hand-derived values.
module tb_mem_arb_a;
  import mem_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  mem_arb_a_if d_if ();
  mem_arb_a_if s_if ();
  mem_arb_a_if t_if ();

  mem_arb_a u_d (
    .clk (clk),
    .rst (rst),
    .bus (d_if)
  );

  mem_arb_a #(
    .MAX_ROW (4),
    .MAX_COL (4)
  ) u_s (
    .clk (clk),
    .rst (rst),
    .bus (s_if)
  );

  mem_arb_a #(
    .STARVE_TH (5)
  ) u_t (
    .clk (clk),
    .rst (rst),
    .bus (t_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM stand-ins: read data = low address byte ^ 0x5A, one cycle late
  always @(posedge clk) begin
    d_if.mem2da_i <= d_if.addra_o[7:0] ^ 8'h5A;
    s_if.mem2da_i <= s_if.addra_o[7:0] ^ 8'h5A;
    t_if.mem2da_i <= t_if.addra_o[7:0] ^ 8'h5A;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic idle_all();
    d_if.pixel_en_i = 1'b0;
    d_if.pixel_i    = '0;
    d_if.rd_req_i   = 1'b0;
    d_if.rd_addr_i  = '0;
    s_if.pixel_en_i = 1'b0;
    s_if.pixel_i    = '0;
    s_if.rd_req_i   = 1'b0;
    s_if.rd_addr_i  = '0;
    t_if.pixel_en_i = 1'b0;
    t_if.pixel_i    = '0;
    t_if.rd_req_i   = 1'b0;
    t_if.rd_addr_i  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_all();
    #1;
    check("rst_lvl", 32'(d_if.fifo_level_o), 0);
    check("rst_ovf", 32'(d_if.ovf_o), 0);
    check("rst_ena", 32'(d_if.ena_o), 0);
    check("rst_vld", 32'(d_if.rd_valid_o), 0);
    check("rst_t_ovf", 32'(t_if.ovf_o), 0);
    check("rst_t_lvl", 32'(t_if.fifo_level_o), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst   = 1'b1;
    idle_all();
    d_if.mem2da_i = '0;
    s_if.mem2da_i = '0;
    t_if.mem2da_i = '0;

    // 5 pixels, no reads: each written one cycle after arrival
    do_reset();
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      d_if.pixel_en_i = (j < 5);
      d_if.pixel_i    = 8'(8'h10 + j);
      #1;
      if (j == 0) begin
        check("wr_nobypass", 32'(d_if.ena_o), 0);
      end else if (j <= 5) begin
        check("wr_ena", 32'(d_if.ena_o), 1);
        check("wr_wea", 32'(d_if.wea_o), 1);
        check("wr_addr", 32'(d_if.addra_o), j - 1);
        check("wr_data", 32'(d_if.d2mema_o),
              32'h10 + j - 1);
      end else begin
        check("wr_idle_ena", 32'(d_if.ena_o), 0);
        check("wr_idle_lvl",
              32'(d_if.fifo_level_o), 0);
      end
    end

    // Reads at addr 7 with pixels every cycle until level hits 3
    do_reset();
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      d_if.rd_req_i   = 1'b1;
      d_if.rd_addr_i  = 19'd7;
      d_if.pixel_en_i = 1'b1;
      d_if.pixel_i    = 8'(8'h20 + j);
      #1;
      check("mix_gnt", 32'(d_if.rd_gnt_o),
            (j < 3) ? 1 : 0);
      check("mix_wea", 32'(d_if.wea_o),
            (j < 3) ? 0 : 1);
      check("mix_lvl", 32'(d_if.fifo_level_o),
            (j < 3) ? j : 3);
      check("mix_vld", 32'(d_if.rd_valid_o),
            (j >= 1 && j <= 3) ? 1 : 0);
      if (j == 1)
        check("mix_rdata", 32'(d_if.rd_data_o),
              32'h5D);
      if (j == 3)
        check("mix_waddr", 32'(d_if.addra_o), 0);
      check("mix_ovf", 32'(d_if.ovf_o), 0);
    end

    // In-range read latency, then out-of-range rejection
    do_reset();
    @(negedge clk);
    d_if.rd_req_i  = 1'b1;
    d_if.rd_addr_i = 19'd100;
    #1;
    check("rd_gnt", 32'(d_if.rd_gnt_o), 1);
    check("rd_ena", 32'(d_if.ena_o), 1);
    check("rd_wea", 32'(d_if.wea_o), 0);
    check("rd_addr", 32'(d_if.addra_o), 100);
    check("rd_err0", 32'(d_if.rd_err_o), 0);
    @(negedge clk);
    d_if.rd_addr_i = 19'd291600;
    #1;
    check("rd_vld", 32'(d_if.rd_valid_o), 1);
    check("rd_data", 32'(d_if.rd_data_o), 32'h3E);
    check("oor_gnt", 32'(d_if.rd_gnt_o), 0);
    check("oor_err", 32'(d_if.rd_err_o), 1);
    check("oor_ena", 32'(d_if.ena_o), 0);
    @(negedge clk);
    d_if.rd_req_i = 1'b0;
    #1;
    check("oor_vld", 32'(d_if.rd_valid_o), 0);
    check("oor_data", 32'(d_if.rd_data_o), 0);
    check("oor_err1", 32'(d_if.rd_err_o), 0);

    // 4x4 frame: done on addr 15, 17th pixel wraps to addr 0
    do_reset();
    for (int j = 0; j < 18; j++) begin
      @(negedge clk);
      s_if.pixel_en_i = (j <= 16);
      s_if.pixel_i    = 8'(j);
      #1;
      check("fr_done", 32'(s_if.frame_done_o),
            (j == 16) ? 1 : 0);
      if (j >= 1) begin
        check("fr_ena", 32'(s_if.ena_o), 1);
        check("fr_addr", 32'(s_if.addra_o),
              (j - 1) % 16);
      end
      if (j == 17)
        check("fr_wrap_data",
              32'(s_if.d2mema_o), 16);
    end

    // STARVE_TH=5: reads hold off writes, 5th pixel is dropped
    do_reset();
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      t_if.rd_req_i   = 1'b1;
      t_if.rd_addr_i  = '0;
      t_if.pixel_en_i = 1'b1;
      t_if.pixel_i    = 8'(8'h30 + j);
      #1;
      check("st_gnt", 32'(t_if.rd_gnt_o), 1);
      check("st_lvl", 32'(t_if.fifo_level_o), j);
      check("st_ovf0", 32'(t_if.ovf_o), 0);
    end
    for (int j = 5; j < 10; j++) begin
      @(negedge clk);
      t_if.rd_req_i   = 1'b0;
      t_if.pixel_en_i = 1'b0;
      #1;
      check("st_ovf1", 32'(t_if.ovf_o), 1);
      if (j < 9) begin
        check("st_lvl_d", 32'(t_if.fifo_level_o),
              9 - j);
        check("st_waddr", 32'(t_if.addra_o), j - 5);
        check("st_wdata", 32'(t_if.d2mema_o),
              32'h30 + j - 5);
      end else begin
        check("st_ena_end", 32'(t_if.ena_o), 0);
      end
    end

    // Reset with 3 buffered pixels and a read in flight
    do_reset();
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      d_if.rd_req_i   = 1'b1;
      d_if.rd_addr_i  = 19'd7;
      d_if.pixel_en_i = 1'b1;
      d_if.pixel_i    = 8'(8'h40 + j);
      #1;
      check("mr_lvl", 32'(d_if.fifo_level_o), j);
    end
    @(negedge clk);
    rst = 1'b1;
    idle_all();
    #1;
    check("mr_lvl0", 32'(d_if.fifo_level_o), 0);
    check("mr_ovf", 32'(d_if.ovf_o), 0);
    check("mr_vld", 32'(d_if.rd_valid_o), 0);
    check("mr_ena", 32'(d_if.ena_o), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      #1;
      check("mr_quiet", 32'(d_if.ena_o), 0);
    end
    @(negedge clk);
    d_if.pixel_en_i = 1'b1;
    d_if.pixel_i    = 8'h77;
    #1;
    check("mr_nobyp", 32'(d_if.ena_o), 0);
    @(negedge clk);
    d_if.pixel_en_i = 1'b0;
    #1;
    check("mr_wea", 32'(d_if.wea_o), 1);
    check("mr_addr", 32'(d_if.addra_o), 0);
    check("mr_data", 32'(d_if.d2mema_o), 32'h77);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arb_a.md
MEM_ARB_A -- requirements
Module: mem_arb_A

Interface
REQ-001 SHALL have parameter MAX_ROW, default 540, frame height in pixels.
REQ-002 SHALL have parameter MAX_COL, default 540, frame width in pixels.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, pixel write-buffer entries.
REQ-004 SHALL have parameter STARVE_TH, default 3, FIFO level that forces write priority.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port pixel_i  input  8  incoming pixel.
REQ-008 SHALL have port pixel_en_i  input  1  pixel_i valid this cycle (no backpressure).
REQ-009 SHALL have port rd_req_i  input  1  read request.
REQ-010 SHALL have port rd_addr_i  input  19  read address.
REQ-011 SHALL have port rd_gnt_o  output  1  read request accepted this cycle.
REQ-012 SHALL have port rd_valid_o  output  1  rd_data_o valid.
REQ-013 SHALL have port rd_data_o  output  8  read data.
REQ-014 SHALL have port rd_err_o  output  1  one-cycle pulse, out-of-range read rejected.
REQ-015 SHALL have ports ena_o, wea_o (output 1), addra_o (output 19), d2mema_o (output 8), mem2da_i (input 8): single-port BRAM, 1-cycle read latency.
REQ-016 SHALL have port frame_done_o  output  1  one-cycle pulse on write of last frame pixel.
REQ-017 SHALL have port ovf_o  output  1  sticky pixel-drop flag.
REQ-018 SHALL have port fifo_level_o  output  3  current FIFO occupancy.

Function
REQ-019 Accepted pixels SHALL be pushed into the FIFO in arrival order; one BRAM write pops one entry.
REQ-020 Per-cycle grant SHALL be: WR if level >= STARVE_TH; else RD if rd_req_i; else WR if level > 0; else NONE.
REQ-021 rd_gnt_o SHALL be combinational, high only in a RD-grant cycle.
REQ-022 rd_req_i with rd_addr_i >= MAX_ROW*MAX_COL SHALL not be granted, SHALL not access BRAM, and SHALL pulse rd_err_o the same cycle.
REQ-023 On WR grant: ena_o=1, wea_o=1, addra_o=write pointer, d2mema_o=FIFO head.
REQ-024 On RD grant: ena_o=1, wea_o=0, addra_o=rd_addr_i; on NONE: ena_o=0, wea_o=0, addra_o=0, d2mema_o=0.
REQ-025 rd_valid_o SHALL be high exactly one cycle after each RD grant, with rd_data_o=mem2da_i; rd_data_o=0 otherwise.
REQ-026 Write pointer SHALL increment per WR grant, wrap from MAX_ROW*MAX_COL-1 to 0, and pulse frame_done_o on the write to MAX_ROW*MAX_COL-1.
REQ-027 Push while full with simultaneous pop SHALL be accepted; push while full without pop SHALL drop the pixel and set ovf_o.
REQ-028 Push and pop when empty SHALL not bypass: the pixel is written no earlier than the next cycle.
REQ-029 A registered last-grant state (NONE/WR/RD) SHALL drive rd_valid_o generation.

Reset
REQ-030 While rst is high: FIFO empty, write pointer 0, last-grant NONE, ovf_o 0, all outputs 0.
REQ-031 Reset mid-frame or mid-read SHALL discard buffered pixels and any pending rd_valid_o; first post-reset write SHALL target address 0.

Structure
REQ-032 Package mem_pkg SHALL hold ADDR_W=19, DATA_W=8, grant enum {GNT_NONE, GNT_WR, GNT_RD}.
REQ-033 FIFO SHALL be a sub-module px_fifo (DATA_W wide, FIFO_DEPTH deep, push/pop/full/empty/level).

Verification
REQ-034 Reset, then 5 pixels 0x10..0x14 with no reads -> BRAM writes addr 0..4, data 0x10..0x14, each one cycle after arrival.
REQ-035 Continuous rd_req_i at addr 7 plus pixels every cycle -> reads granted until level=3, then writes granted; ovf_o stays 0.
REQ-036 Read addr 100 granted in cycle N -> rd_valid_o=1 in N+1 with rd_data_o=mem2da_i; rd_addr_i=291600 -> rd_gnt_o=0, rd_err_o pulse, ena_o=0.
REQ-037 Write MAX_ROW*MAX_COL pixels (use MAX_ROW=MAX_COL=4) -> frame_done_o pulses on write to addr 15; next pixel written to addr 0.
REQ-038 Fill FIFO (FIFO_DEPTH=4) while blocking writes via forced read priority on small STARVE_TH=5 override -> 5th pixel dropped, ovf_o=1 until rst.
REQ-039 Assert rst with 3 buffered pixels -> level 0, ovf_o 0, no BRAM write after release until new pixel arrives, then addr 0.
